// File: rtl/axum_uart_loader.sv
// Axum serial boot loader: UART 8N1 receiver feeding a frame parser
// that writes the image to SRAM as a bus host while holding the core in reset.
module axum_uart_loader #(
  parameter int ClksPerBit = 104
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        boot_en_i,
  input  logic        rx_i,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic        host_err_i,
  output logic        core_rst_no,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [15:0] BitLast  = 16'(ClksPerBit - 1);
  localparam logic [15:0] HalfLast = 16'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_e;

  typedef enum logic [3:0] {
    S_INIT, S_MAGIC, S_ADDR, S_LEN, S_DATA,
    S_REQ, S_WAIT, S_DONE, S_ERR
  } st_e;

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  rx_e         rx_st_q, rx_st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_vld_q, rx_vld_d;

  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  st_e         st_q, st_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [29:0] wcnt_q, wcnt_d;

  logic        consume;
  logic        active;

  // UART receiver: edge detect, half-bit recheck, mid-bit sampling
  always_comb begin
    rx_st_d  = rx_st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    rx_sh_d  = rx_sh_q;
    rx_vld_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_st_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == BitLast) begin
          rx_st_d  = RX_IDLE;
          rx_vld_d = rx_s2_q;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign active  = (st_q != S_DONE) && (st_q != S_ERR);
  assign consume = full_q && (st_q inside {
    S_MAGIC, S_ADDR, S_LEN, S_DATA, S_DONE, S_ERR});

  // Holding register plus frame parser and bus write sequencing
  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    st_d    = st_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    if (consume) full_d = 1'b0;
    if (rx_vld_q) begin
      hold_d = rx_sh_q;
      full_d = 1'b1;
    end
    unique case (st_q)
      S_INIT: st_d = boot_en_i ? S_MAGIC : S_DONE;
      S_MAGIC: begin
        if (consume && hold_q == 8'hA5) begin
          st_d   = S_ADDR;
          bcnt_d = '0;
        end
      end
      S_ADDR: begin
        if (consume) begin
          sh_d   = {hold_q, sh_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            addr_d = {hold_q, sh_q[23:2], 2'b00};
            st_d   = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (consume) begin
          sh_d   = {hold_q, sh_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wcnt_d = {hold_q, sh_q[23:2]};
            st_d   = ({hold_q, sh_q[23:2]} == 30'd0)
                     ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (consume) begin
          sh_d   = {hold_q, sh_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wdata_d = {hold_q, sh_q};
            st_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (host_gnt_i) st_d = S_WAIT;
      end
      S_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            st_d = S_ERR;
          end else begin
            addr_d = addr_q + 32'd4;
            wcnt_d = wcnt_q - 30'd1;
            st_d   = (wcnt_q == 30'd1) ? S_DONE : S_DATA;
          end
        end
      end
      S_DONE: st_d = S_DONE;
      S_ERR:  st_d = S_ERR;
      default: st_d = S_ERR;
    endcase
    if (rx_vld_q && full_q && !consume && active)
      st_d = S_ERR;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      rx_sh_q  <= '0;
      rx_vld_q <= 1'b0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      st_q     <= S_INIT;
      bcnt_q   <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      rx_s1_q  <= rx_i;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_vld_q <= rx_vld_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      st_q     <= st_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign host_req_o   = (st_q == S_REQ);
  assign host_we_o    = host_req_o;
  assign host_be_o    = host_req_o ? 4'hF : 4'h0;
  assign host_addr_o  = addr_q;
  assign host_wdata_o = wdata_q;
  assign core_rst_no  = (st_q == S_DONE);
  assign err_o        = (st_q == S_ERR);
  assign busy_o       = active;

endmodule
